// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and defaults for the memory access arbiter slice (package mem_arb_pkg).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RWAIT = 2'd3
  } arb_state_e;

  // wr_count CSR is read-only, so parking on it has no side effects on the array.
  localparam logic [15:0] DEF_PARK_ADDR    = 16'h0018;
  localparam logic [15:0] DEF_CHIP_EN_ADDR = 16'h0020;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr.sv
// Combinational round-robin pick: the search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  int               cand;
  logic [IDX_W-1:0] ci;

  always_comb begin
    any     = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    cand    = 0;
    ci      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_gnt) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      ci = IDX_W'(cand);
      if (!any && req[ci]) begin
        any        = 1'b1;
        gnt_oh[ci] = 1'b1;
        gnt_idx    = ci;
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin sequencer sharing one registered-read memory bus among NUM_REQ requesters.
// Define MEM_ARB_INIT_EN to issue the CHIP_EN bring-up write straight out of reset.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR    = ADDR_WIDTH'(DEF_PARK_ADDR),
  parameter logic [ADDR_WIDTH-1:0] CHIP_EN_ADDR = ADDR_WIDTH'(DEF_CHIP_EN_ADDR)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          mem_wr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int IDX_W = idx_w(NUM_REQ);

`ifdef MEM_ARB_INIT_EN
  localparam arb_state_e RESET_STATE = INIT;
`else
  localparam arb_state_e RESET_STATE = IDLE;
`endif

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]      last_gnt_q, last_gnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req      (req),
    .last_gnt (last_gnt_q),
    .any      (pick_any),
    .gnt_oh   (pick_oh),
    .gnt_idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= PARK_ADDR;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The bring-up write reuses ISSUE so it parks the bus exactly like a granted write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = ISSUE;
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = mem_wr_q ? IDLE : RWAIT;
      RWAIT:   state_d = IDLE;
      default: state_d = RESET_STATE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    last_gnt_d  = last_gnt_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      INIT: begin
        mem_wr_d    = 1'b1;
        mem_addr_d  = CHIP_EN_ADDR;
        mem_wdata_d = DATA_WIDTH'(1);
      end
      IDLE: begin
        if (pick_any) begin
          gnt_d       = pick_oh;
          last_gnt_d  = pick_idx;
          mem_wr_d    = req_wr[pick_idx];
          mem_addr_d  = addr_v[pick_idx];
          mem_wdata_d = req_wr[pick_idx] ? wdata_v[pick_idx] : '0;
        end
      end
      ISSUE: begin
        mem_wr_d    = 1'b0;
        mem_addr_d  = PARK_ADDR;
        mem_wdata_d = '0;
      end
      RWAIT: begin
        // last_gnt still names the reader: nothing is granted while a read is in flight.
        rdata_d              = mem_rdata;
        rvalid_d[last_gnt_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Random + directed bench: a transaction-level model predicts grants and read returns,
// a negedge monitor compares every cycle against the queued expectations.
module tb_mem_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [AW-1:0] PARK   = 16'h0018;
  localparam logic [AW-1:0] CHIPEN = 16'h0020;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_clr = 1'b1;
  logic [N-1:0]    req = '0, req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            busy, mem_wr;
  logic [AW-1:0]   mem_addr;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: write at clock edge, read data registered one cycle late.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:0]];
  end

  typedef struct {
    int            cyc;
    int            who;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] last_rdata;
  int cyc, free_at, busy_from, last;
  int n_vec = 0, n_err = 0;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic logic [N-1:0] oh(input int w);
    oh = '0;
    oh[w] = 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: arbitration happens whenever the bus is free and someone requests.
  int   md_w;
  logic md_found;
  exp_t md_e;
  always @(negedge clk) begin
    if (!reset && cyc >= free_at && req != '0) begin
      md_found = 1'b0;
      md_w = 0;
      for (int k = 1; k <= N; k++)
        if (!md_found && req[(last + k) % N]) begin
          md_found = 1'b1;
          md_w = (last + k) % N;
        end
      md_e.cyc  = cyc + 1;
      md_e.who  = md_w;
      md_e.wr   = req_wr[md_w];
      md_e.addr = req_addr[md_w*AW +: AW];
      md_e.data = req_wr[md_w] ? req_wdata[md_w*DW +: DW] : '0;
      gq.push_back(md_e);
      last = md_w;
      busy_from = cyc + 1;
      if (md_e.wr) begin
        ref_mem[md_e.addr[7:0]] = md_e.data;
        free_at = cyc + 2;
      end else begin
        md_e.cyc  = cyc + 3;
        md_e.data = ref_mem[md_e.addr[7:0]];
        rq.push_back(md_e);
        free_at = cyc + 3;
      end
    end
  end

  // Monitor
  exp_t          m_g, m_r;
  logic          m_gh, m_rh, m_ewr;
  logic [AW-1:0] m_ea;
  logic [DW-1:0] m_ed;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, PARK);
      chk("rst_mem_wdata", mem_wdata, 0);
    end else begin
      m_gh = (gq.size() > 0) && (gq[0].cyc == cyc);
      if (m_gh) m_g = gq.pop_front();
      chk("gnt", gnt, m_gh ? oh(m_g.who) : '0);
      m_ewr = 1'b0; m_ea = PARK; m_ed = '0;
      if (m_gh) begin
        m_ewr = m_g.wr; m_ea = m_g.addr; m_ed = m_g.data;
      end
`ifdef MEM_ARB_INIT_EN
      else if (cyc == 1) begin
        m_ewr = 1'b1; m_ea = CHIPEN; m_ed = 32'h1;
      end
`endif
      chk("mem_wr", mem_wr, m_ewr);
      chk("mem_addr", mem_addr, m_ea);
      chk("mem_wdata", mem_wdata, m_ed);
      chk("busy", busy, (cyc >= busy_from) && (cyc < free_at));
      m_rh = (rq.size() > 0) && (rq[0].cyc == cyc);
      if (m_rh) begin
        m_r = rq.pop_front();
        last_rdata = m_r.data;
      end
      chk("rvalid", rvalid, m_rh ? oh(m_r.who) : '0);
      chk("rdata", rdata, last_rdata);
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req = '0;
    gq.delete();
    rq.delete();
    last = N - 1;
    last_rdata = '0;
    busy_from = 0;
`ifdef MEM_ARB_INIT_EN
    free_at = 2;
    ref_mem[8'h20] = 32'h1;
`else
    free_at = 0;
`endif
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_one(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #1;
      if (gnt[i]) got = 1'b1;
    end
    req[i] = 1'b0;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL grant_timeout req%0d got=none want=gnt", i);
    end
    idle(4);
  endtask

  task automatic new_req(input int i);
    req_wr[i] = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW] = AW'($urandom_range(0, 15));
    req_wdata[i*DW +: DW] = $urandom;
    req[i] = 1'b1;
  endtask

  // Requesters hold until granted, then drop for a cycle; wd_pct adds early withdrawals.
  task automatic run_random(input int cycles, input int load, input int wd_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (req[i]) begin
          if ($urandom_range(0, 99) < wd_pct) req[i] = 1'b0;
        end else if ($urandom_range(0, 99) < load) new_req(i);
      end
    end
    req = '0;
    idle(5);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    do_reset(2);

    drive_one(0, 1'b1, 16'd3, 32'hA5A5_0001);
    drive_one(0, 1'b0, 16'd3, 32'h0);
    drive_one(3, 1'b0, CHIPEN, 32'h0);
    idle(10);

    // req2 pulses only while req1's write is in ISSUE
    req_wr[1] = 1'b1; req_addr[1*AW +: AW] = 16'd5; req_wdata[1*DW +: DW] = 32'h1111_2222;
    req[1] = 1'b1;
    idle(1);
    req[1] = 1'b0;
    req_wr[2] = 1'b1; req_addr[2*AW +: AW] = 16'd6; req_wdata[2*DW +: DW] = 32'h3333_4444;
    req[2] = 1'b1;
    idle(1);
    req[2] = 1'b0;
    idle(4);

    for (int i = 0; i < N; i++) new_req(i);
    run_random(40, 100, 0);

    // reset lands in RWAIT of req0's read
    req_wr[0] = 1'b0; req_addr[0*AW +: AW] = 16'd3;
    req[0] = 1'b1;
    idle(1);
    req[0] = 1'b0;
    idle(1);
    do_reset(1);
    idle(3);

    run_random(300, 40, 10);
    run_random(200, 90, 0);
    drive_one(1, 1'b0, 16'd3, 32'h0);

    chk("drain", gq.size() + rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Round-robin arbiter and sequencer that shares one single-port memory/CSR bus among `NUM_REQ` requesters. It owns the `wr`/`addr`/`wdata` pins of the memory and captures its one-cycle-late registered read data. It sits between the agents and the memory model. It optionally performs the CHIP_EN bring-up write after reset, so requesters never see a disabled (tri-stated) memory.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ADDR_WIDTH`, default 16: memory/CSR address width.
- `DATA_WIDTH`, default 32: data width.
- `PARK_ADDR`, default 16'h0018: address driven when the bus is idle (read-only wr_count CSR, so there are no side effects on the memory array).
- `CHIP_EN_ADDR`, default 16'h0020: CHIP_EN CSR address.
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-high.
- `req  in  NUM_REQ`: per-requester request level.
- `req_wr  in  NUM_REQ`: 1 = write, 0 = read.
- `req_addr  in  NUM_REQ*ADDR_WIDTH`: flattened addresses; requester i occupies slice i.
- `req_wdata  in  NUM_REQ*DATA_WIDTH`: flattened write data.
- `gnt  out  NUM_REQ`: one-hot, one-cycle grant pulse.
- `rvalid  out  NUM_REQ`: one-hot, one-cycle read-data-valid pulse.
- `rdata  out  DATA_WIDTH`: read data, valid while `rvalid` is set.
- `busy  out  1`: FSM not in IDLE.
- `mem_wr  out  1`: memory write strobe.
- `mem_addr  out  ADDR_WIDTH`: memory address.
- `mem_wdata  out  DATA_WIDTH`: memory write data.
- `mem_rdata  in  DATA_WIDTH`: memory read data, registered inside the memory.

## Operation
- FSM states:
  - `INIT`: present only with the macro.
  - `IDLE`: evaluate `req`.
  - `ISSUE`: bus driven for the granted requester.
  - `RWAIT`: read data returns.
- `IDLE`:
  - If any `req` bit is set, select the winner round-robin, starting from `last_gnt+1` modulo `NUM_REQ`.
  - Register `gnt[winner]=1`, `mem_wr=req_wr[w]`, `mem_addr=req_addr[w]`, `mem_wdata=req_wdata[w]`, and update `last_gnt`.
  - Go to `ISSUE`.
- `ISSUE`:
  - Write: the memory commits at the end of this cycle. Restore `mem_wr=0` and `mem_addr=PARK_ADDR`, then go to `IDLE`.
  - Read: restore the park values and go to `RWAIT`.
- `RWAIT`: capture `mem_rdata` into `rdata`, register `rvalid[owner]=1`, then go to `IDLE`.
- `req` is sampled only in `IDLE`. The requester holds `req`/`addr`/`wdata` stable until it sees `gnt`. If `req` drops before the grant, the request is forgotten with no error.
- After its `gnt`, a requester must deassert `req` for at least one cycle before re-requesting, otherwise it is arbitrated again.
- `mem_wdata` is zeroed whenever `mem_wr=0`.
- The `last_gnt` reset value is `NUM_REQ-1`, so requester 0 has first priority.
- `rdata` holds its last captured value between reads.

## Timing
- Request seen in `IDLE` at cycle T: `gnt` and the bus are driven in T+1. A write is committed at the end of T+1.
- Read: `rvalid`/`rdata` in T+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset values: `gnt=0`, `rvalid=0`, `rdata=0`, `mem_wr=0`, `mem_addr=PARK_ADDR`, `mem_wdata=0`.
- `busy` is 1 out of reset with the macro and 0 without it. `busy` is decoded combinationally from the state register.
- Reset asserted mid-transaction: the FSM returns to its reset state immediately and no `rvalid` is produced for the aborted read. A write already in `ISSUE` at the reset edge is lost.
- All requesters asserting simultaneously in every arbitration cycle are granted in strict rotation; no requester waits more than `NUM_REQ` grants.

## Configuration
- `MEM_ARB_INIT_EN` defined:
  - The FSM resets into `INIT`, drives `mem_wr=1`, `mem_addr=CHIP_EN_ADDR`, `mem_wdata=1` for exactly one cycle, then enters `IDLE`.
  - No `gnt` is issued during `INIT`.
- Undefined: the FSM resets into `IDLE`. Software must write CHIP_EN through a requester before data reads return defined values.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_e` (`INIT`, `IDLE`, `ISSUE`, `RWAIT`).
  - Default localparams for `PARK_ADDR` and `CHIP_EN_ADDR`.
- Sub-module `rr_arbiter`: `NUM_REQ`-wide combinational round-robin pick from (`req`, `last_gnt`), returning a one-hot vector and an index.

## Test plan
- Single write: req0 writes 0xA5A5_0001 to addr 3 → `gnt[0]` in T+1, `mem_wr=1`, `mem_addr=3`. A later read of addr 3 returns `rvalid[0]` with `rdata=0xA5A5_0001` 2 cycles after its grant.
- Contention: req0..3 all assert and hold → grants in order 0,1,2,3,0. After each requester drops `req` for a cycle and re-asserts, rotation continues from `last_gnt+1`.
- Init (macro on): release reset → cycle 1 shows `mem_addr=0x20`, `mem_wdata=1`, `mem_wr=1`, `busy=1`. The first `gnt` comes no earlier than cycle 2. A CSR read of 0x20 returns 0x0000_0001.
- Idle parking: no requests for 10 cycles → `mem_addr=0x18`, `mem_wr=0` throughout, and the memory array is unchanged.
- Reset mid-read: assert reset in `RWAIT` → no `rvalid`; all outputs hold their reset values on the next cycle.
- Early withdraw: req2 pulses for 1 cycle while the FSM is in `ISSUE` for req1 → `gnt[2]` never asserts.
